// File: rtl/lives_tracker_if.sv
// Bundle of the per-frame game-control inputs and the lives/respawn outputs
// exchanged between the game logic and the lives tracker.
interface lives_tracker_if;
  logic       frame_tick;
  logic       start;
  logic       hit;
  logic [1:0] lives;
  logic       game_over;
  logic       invuln;
  logic       player_visible;
  logic       respawn;

  // Game logic side: drives the pulses and reads back the player status
  modport master (
    output frame_tick, start, hit,
    input  lives, game_over, invuln, player_visible, respawn
  );

  // Tracker side: consumes the pulses and produces the player status
  modport slave (
    input  frame_tick, start, hit,
    output lives, game_over, invuln, player_visible, respawn
  );
endinterface

// File: rtl/lives_tracker.sv
// Player-life bookkeeping FSM. It counts down lives on collisions, sequences
// the explosion and invulnerability phases in video frames, and produces the
// registered controls used by the segment display and the sprite renderer.
module lives_tracker #(
  parameter int START_LIVES   = 3,
  parameter int DEATH_FRAMES  = 60,
  parameter int INVULN_FRAMES = 120,
  parameter int BLINK_SHIFT   = 3
) (
  input  logic            clk,
  input  logic            clr,
  lives_tracker_if.slave  bus_if
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PLAY     = 3'd1,
    DYING    = 3'd2,
    INVULN   = 3'd3,
    GAMEOVER = 3'd4
  } state_t;

  localparam logic [1:0] START_LV    = 2'(START_LIVES);
  localparam logic [7:0] DEATH_LAST  = 8'(DEATH_FRAMES - 1);
  localparam logic [7:0] INVULN_LAST = 8'(INVULN_FRAMES - 1);

  state_t     state_q, state_d;
  logic [1:0] lives_q, lives_d;
  logic [7:0] cnt_q, cnt_d;
  logic       game_over_q, game_over_d;
  logic       invuln_q, invuln_d;
  logic       visible_q, visible_d;
  logic       respawn_q, respawn_d;

  // Next-state, next-lives and frame-counter logic; outputs are derived from
  // the next state so every register reflects the state it is entering.
  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    respawn_d = 1'b0;

    case (state_q)
      IDLE: begin
        // start beats a simultaneous hit, which is simply dropped here
        if (bus_if.start) begin
          state_d = PLAY;
          lives_d = START_LV;
        end
      end
      PLAY: begin
        if (bus_if.hit) begin
          if (lives_q <= 2'd1) begin
            lives_d = 2'd0;
            state_d = GAMEOVER;
          end else begin
            lives_d = lives_q - 2'd1;
            state_d = DYING;
          end
        end
      end
      DYING: begin
        if (bus_if.frame_tick && (cnt_q == DEATH_LAST)) begin
          state_d   = INVULN;
          respawn_d = 1'b1;
        end
      end
      INVULN: begin
        if (bus_if.frame_tick && (cnt_q == INVULN_LAST)) begin
          state_d = PLAY;
        end
      end
      GAMEOVER: begin
        lives_d = 2'd0;
        if (bus_if.start) begin
          state_d = PLAY;
          lives_d = START_LV;
        end
      end
      default: begin
        state_d = IDLE;
        lives_d = START_LV;
      end
    endcase

    // The counter restarts on any state change, even if a tick coincides
    if (state_d != state_q) begin
      cnt_d = 8'd0;
    end else if (bus_if.frame_tick) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end

    game_over_d = (state_d == GAMEOVER);
    invuln_d    = (state_d == INVULN);
    case (state_d)
      DYING, GAMEOVER: visible_d = 1'b0;
      INVULN:          visible_d = ~cnt_d[BLINK_SHIFT];
      default:         visible_d = 1'b1;
    endcase
  end

  // State and output registers with synchronous clear taking priority
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= IDLE;
      lives_q     <= START_LV;
      cnt_q       <= 8'd0;
      game_over_q <= 1'b0;
      invuln_q    <= 1'b0;
      visible_q   <= 1'b1;
      respawn_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      cnt_q       <= cnt_d;
      game_over_q <= game_over_d;
      invuln_q    <= invuln_d;
      visible_q   <= visible_d;
      respawn_q   <= respawn_d;
    end
  end

  assign bus_if.lives          = lives_q;
  assign bus_if.game_over      = game_over_q;
  assign bus_if.invuln         = invuln_q;
  assign bus_if.player_visible = visible_q;
  assign bus_if.respawn        = respawn_q;

endmodule

// File: tb/tb_lives_tracker.sv
// Directed bench for lives_tracker: a behavioural reference model predicts the
// outputs for every driven cycle, queues them, and they are popped and checked
// one cycle later, with extra constant checks at the key milestones.
module tb_lives_tracker;

  localparam int START  = 3;
  localparam int DEATH  = 60;
  localparam int INV    = 120;
  localparam int BLINK  = 3;

  typedef struct packed {
    logic [1:0] lives;
    logic       go;
    logic       inv;
    logic       vis;
    logic       resp;
  } exp_t;

  logic clk;
  logic clr;
  lives_tracker_if bus ();

  lives_tracker #(
    .START_LIVES(START), .DEATH_FRAMES(DEATH),
    .INVULN_FRAMES(INV), .BLINK_SHIFT(BLINK)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus_if(bus.slave)
  );

  exp_t expQ[$];
  int total = 0;
  int bad   = 0;

  // reference model: 0 idle, 1 play, 2 dying, 3 invuln, 4 gameover
  int mState = 0;
  int mLives = START;
  int mCnt   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic modelStep(input bit c, input bit ft, input bit st, input bit h);
    int   nState;
    int   nCnt;
    bit   resp;
    exp_t e;
    nState = mState;
    nCnt   = mCnt;
    resp   = 1'b0;
    if (c) begin
      nState = 0;
      mLives = START;
      nCnt   = 0;
    end else begin
      case (mState)
        0: if (st) begin nState = 1; mLives = START; end
        1: if (h) begin
             if (mLives == 1) begin mLives = 0; nState = 4; end
             else begin mLives = mLives - 1; nState = 2; end
           end
        2: if (ft && mCnt == DEATH - 1) begin nState = 3; resp = 1'b1; end
        3: if (ft && mCnt == INV - 1) nState = 1;
        4: if (st) begin nState = 1; mLives = START; end
        default: nState = 0;
      endcase
      if (nState != mState) nCnt = 0;
      else if (ft) nCnt = (mCnt + 1) % 256;
    end
    mState  = nState;
    mCnt    = nCnt;
    e.lives = 2'(mLives);
    e.go    = (mState == 4);
    e.inv   = (mState == 3);
    e.vis   = (mState == 2 || mState == 4) ? 1'b0 :
              (mState == 3) ? ~((mCnt >> BLINK) & 1) : 1'b1;
    e.resp  = resp;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Drive one cycle of inputs, predict it, then compare after the edge
  task automatic applyStimulus(input bit c, input bit ft, input bit st, input bit h);
    exp_t e;
    @(negedge clk);
    clr            = c;
    bus.frame_tick = ft;
    bus.start      = st;
    bus.hit        = h;
    modelStep(c, ft, st, h);
    @(posedge clk);
    #1;
    e = expQ.pop_front();
    checkOutput("lives",     int'(bus.lives),          int'(e.lives));
    checkOutput("game_over", int'(bus.game_over),      int'(e.go));
    checkOutput("invuln",    int'(bus.invuln),         int'(e.inv));
    checkOutput("visible",   int'(bus.player_visible), int'(e.vis));
    checkOutput("respawn",   int'(bus.respawn),        int'(e.resp));
  endtask

  // n frame ticks, with a hit injected on every fourth cycle when requested
  task automatic runTicks(input int n, input bit withHits);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, withHits && (i % 4 == 1));
    end
  endtask

  initial begin
    clr = 1'b0;
    bus.frame_tick = 1'b0;
    bus.start = 1'b0;
    bus.hit = 1'b0;
    @(negedge clk);

    // 1: clear, then hits in IDLE are ignored
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_lives", int'(bus.lives), 3);
    checkOutput("rst_vis", int'(bus.player_visible), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("idle_hit_lives", int'(bus.lives), 3);

    // 2/3: start, first death with hits ignored in DYING and INVULN
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("hit1_lives", int'(bus.lives), 2);
    checkOutput("hit1_vis", int'(bus.player_visible), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    runTicks(DEATH - 1, 1'b1);
    checkOutput("pre_respawn", int'(bus.respawn), 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("respawn_pulse", int'(bus.respawn), 1);
    checkOutput("respawn_inv", int'(bus.invuln), 1);
    runTicks(8, 1'b1);
    checkOutput("blink_off", int'(bus.player_visible), 0);
    checkOutput("respawn_one", int'(bus.respawn), 0);
    runTicks(INV - 9, 1'b1);
    checkOutput("inv_hold_lives", int'(bus.lives), 2);
    checkOutput("inv_last", int'(bus.invuln), 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("inv_done", int'(bus.invuln), 0);
    checkOutput("inv_done_vis", int'(bus.player_visible), 1);

    // 4: second death with hit coinciding with a tick, then game over
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("hit2_lives", int'(bus.lives), 1);
    runTicks(DEATH + INV, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("hit3_lives", int'(bus.lives), 0);
    checkOutput("hit3_go", int'(bus.game_over), 1);
    runTicks(5, 1'b1);
    checkOutput("go_hold", int'(bus.lives), 0);

    // 5: restart from GAMEOVER, and start+hit together in IDLE
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("restart_lives", int'(bus.lives), 3);
    checkOutput("restart_go", int'(bus.game_over), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("start_hit_lives", int'(bus.lives), 3);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("in_play_hit", int'(bus.lives), 2);

    // 6: clear in the middle of INVULN
    runTicks(DEATH + 10, 1'b0);
    checkOutput("mid_inv", int'(bus.invuln), 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("clr_inv", int'(bus.invuln), 0);
    checkOutput("clr_lives", int'(bus.lives), 3);
    checkOutput("clr_vis", int'(bus.player_visible), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
